// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM states, parameter
// defaults and small elaboration-time helpers.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } seq_state_t;

   localparam int unsigned DEF_RST_CYCLES   = 16;
   localparam int unsigned DEF_LOCK_STABLE  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT = 500000;   // 10 ms at 50 MHz
   localparam int unsigned DEF_MAX_RETRY    = 3;

   localparam logic [7:0]  LOSS_CNT_MAX     = 8'hFF;

   // Largest of three cycle counts; sizes the shared state counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset.
module bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw level through two flops; reset clears both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream reset. Retries on lock timeout, gives up after
// MAX_RETRY retries, and counts lock losses while running.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
   parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] lock_loss_cnt
);

   localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
   localparam int unsigned CNT_W   = clog2_min1(CNT_MAX + 1);
   localparam int unsigned RETRY_W = clog2_min1(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
   localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

   seq_state_t         state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
   logic               loss_inc;
   logic               locked_s;

   bit_sync u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Next-state, counter and retry decisions; relock_req outranks all events.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_cnt;
      loss_inc  = 1'b0;

      if (relock_req && (state != ST_PLL_RST)) begin
         state_nxt = ST_PLL_RST;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            ST_PLL_RST: begin
               if (cnt == RST_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_nxt = ST_STABLE;
                  cnt_nxt   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_nxt = '0;
                  if (retry_cnt < RETRY_LIMIT) begin
                     state_nxt = ST_PLL_RST;
                     retry_nxt = retry_cnt + RETRY_ONE;
                  end else begin
                     state_nxt = ST_FAIL;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            ST_STABLE: begin
               if (!locked_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_nxt = ST_PLL_RST;
                  cnt_nxt   = '0;
                  loss_inc  = 1'b1;
               end
            end
            ST_FAIL: begin
               cnt_nxt = '0;
            end
            default: begin
               state_nxt = ST_PLL_RST;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end
         endcase
      end
   end

   // State, counters and outputs; outputs decode the next state so they
   // are valid in the first cycle of each new state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state         <= ST_PLL_RST;
         cnt           <= '0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
         pll_rst       <= 1'b1;
         sys_rst       <= 1'b1;
         ready         <= 1'b0;
         fail          <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         if (loss_inc && (lock_loss_cnt != LOSS_CNT_MAX)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
         end
         pll_rst <= (state_nxt == ST_PLL_RST);
         sys_rst <= (state_nxt != ST_RUN);
         ready   <= (state_nxt == ST_RUN);
         fail    <= (state_nxt == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

   localparam int unsigned T_RST     = 4;
   localparam int unsigned T_STABLE  = 8;
   localparam int unsigned T_TIMEOUT = 32;
   localparam int unsigned T_RETRY   = 2;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;
   localparam int P_FAIL = 4;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] lock_loss_cnt;

   int vectors;
   int miscompares;

   pll_reset_sequencer #(
      .RST_CYCLES   (T_RST),
      .LOCK_STABLE  (T_STABLE),
      .LOCK_TIMEOUT (T_TIMEOUT),
      .MAX_RETRY    (T_RETRY)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .relock_req    (relock_req),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .fail          (fail),
      .lock_loss_cnt (lock_loss_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Behavioural model: phase plus absolute entry time; dwell = edges since entry.
   int cyc;
   int phase;
   int phase_start;
   int retries;
   int losses;
   bit hist[$];

   initial begin
      cyc = 0; phase = P_RST; phase_start = 0; retries = 0; losses = 0;
   end

   task automatic enter(input int p);
      phase       = p;
      phase_start = cyc;
   endtask

   function automatic logic [3:0] exp_out(input int p);
      case (p)
         P_RST:   return 4'b1100;
         P_WAIT:  return 4'b0100;
         P_STAB:  return 4'b0100;
         P_RUN:   return 4'b0010;
         default: return 4'b0101;
      endcase
   endfunction

   always @(posedge refclk) begin
      bit ls;
      int dwell;
      cyc++;
      if (rst) begin
         enter(P_RST);
         retries = 0;
         losses  = 0;
         hist.delete();
      end else begin
         ls    = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
         dwell = cyc - phase_start;
         if (relock_req && phase != P_RST) begin
            enter(P_RST);
            retries = 0;
         end else begin
            case (phase)
               P_RST:  if (dwell == T_RST) enter(P_WAIT);
               P_WAIT: begin
                  if (ls) enter(P_STAB);
                  else if (dwell == T_TIMEOUT) begin
                     if (retries < T_RETRY) begin
                        retries++;
                        enter(P_RST);
                     end else enter(P_FAIL);
                  end
               end
               P_STAB: begin
                  if (!ls) enter(P_WAIT);
                  else if (dwell == T_STABLE) begin
                     retries = 0;
                     enter(P_RUN);
                  end
               end
               P_RUN: begin
                  if (!ls) begin
                     if (losses < 255) losses++;
                     enter(P_RST);
                  end
               end
               default: ;
            endcase
         end
         hist.push_back(pll_locked);
         if (hist.size() > 2) void'(hist.pop_front());
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge refclk) begin
      logic [3:0] act;
      logic [3:0] exp;
      act = {pll_rst, sys_rst, ready, fail};
      exp = exp_out(phase);
      vectors++;
      if (act !== exp || lock_loss_cnt !== 8'(losses)) begin
         miscompares++;
         if (miscompares <= 20)
            $display("FAIL cycle_%0d outputs: got pll_rst/sys_rst/ready/fail=%b loss=%0d, expected %b loss=%0d",
                     cyc, act, lock_loss_cnt, exp, losses);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic count_pll_rst_high(output int k);
      k = 0;
      while (pll_rst === 1'b1 && k < 50) begin
         k++;
         @(negedge refclk);
      end
   endtask

   task automatic wait_ready(output int k);
      k = 0;
      while (ready !== 1'b1 && k < 200) begin
         @(negedge refclk);
         k++;
      end
   endtask

   task automatic wait_pll_rst(output int k);
      k = 0;
      while (pll_rst !== 1'b1 && k < 50) begin
         @(negedge refclk);
         k++;
      end
   endtask

   // Called with rst asserted at a falling edge; releases it and runs to RUN.
   task automatic nominal(input string tag);
      int k;
      rst = 1'b0;
      count_pll_rst_high(k);
      check({tag, "_pll_rst_width"}, k, 4);
      repeat (6) @(negedge refclk);
      pll_locked = 1'b1;
      wait_ready(k);
      check({tag, "_ready_latency"}, k, 11);
      check({tag, "_sys_rst"}, int'(sys_rst), 0);
      check({tag, "_loss_cnt"}, int'(lock_loss_cnt), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pll_rst"}, int'(pll_rst), 1);
      check({tag, "_sys_rst"}, int'(sys_rst), 1);
      check({tag, "_ready"},   int'(ready), 0);
      check({tag, "_fail"},    int'(fail), 0);
      check({tag, "_loss"},    int'(lock_loss_cnt), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, rises, highs, r1, r2, r3;
      logic prev;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      repeat (3) @(negedge refclk);
      check_reset_outputs("reset");

      nominal("nom");

      // Loss of lock while running.
      @(negedge refclk);
      pll_locked = 1'b0;
      wait_pll_rst(k);
      check("loss_pll_rst_latency", k, 3);
      check("loss_ready", int'(ready), 0);
      check("loss_sys_rst", int'(sys_rst), 1);
      check("loss_cnt_one", int'(lock_loss_cnt), 1);

      // relock_req on the cycle STABLE would otherwise enter RUN.
      count_pll_rst_high(k);
      repeat (2) @(negedge refclk);
      pll_locked = 1'b1;
      repeat (10) @(negedge refclk);
      relock_req = 1'b1;
      @(negedge refclk);
      relock_req = 1'b0;
      check("prio_pll_rst", int'(pll_rst), 1);
      check("prio_ready", int'(ready), 0);

      // One-cycle lock glitch at STABLE counter 5.
      count_pll_rst_high(k);
      repeat (4) @(negedge refclk);
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      k = 0;
      highs = 0;
      while (ready !== 1'b1 && k < 60) begin
         @(negedge refclk);
         k++;
         if (pll_rst === 1'b1) highs++;
      end
      check("glitch_no_pll_rst", highs, 0);
      check("glitch_ready_latency", k, 11);

      // Repeated losses saturate the loss counter.
      for (int i = 0; i < 260; i++) begin
         @(negedge refclk);
         pll_locked = 1'b0;
         wait_pll_rst(k);
         pll_locked = 1'b1;
         wait_ready(k);
      end
      check("loss_saturated", int'(lock_loss_cnt), 255);

      // Permanent loss: retries then FAIL.
      @(negedge refclk);
      pll_locked = 1'b0;
      k = 0; rises = 0; highs = 0; r1 = 0; r2 = 0; r3 = 0;
      prev = pll_rst;
      while (fail !== 1'b1 && k < 400) begin
         @(negedge refclk);
         k++;
         if (pll_rst === 1'b1 && prev !== 1'b1) begin
            rises++;
            if (rises == 1) r1 = k;
            if (rises == 2) r2 = k;
            if (rises == 3) r3 = k;
         end
         if (pll_rst === 1'b1) highs++;
         prev = pll_rst;
      end
      check("fail_reached", int'(fail), 1);
      check("fail_pulse_count", rises, 3);
      check("fail_pulse_cycles", highs, 12);
      check("fail_gap_1_2", r2 - r1, 36);
      check("fail_gap_2_3", r3 - r2, 36);
      check("fail_after_last", k - r3, 36);
      repeat (20) @(negedge refclk);
      check("fail_sticky", int'(fail), 1);

      // relock_req leaves FAIL; a repeat request during PLL_RST is ignored.
      relock_req = 1'b1;
      @(negedge refclk);
      check("relock_fail_cleared", int'(fail), 0);
      check("relock_pll_rst", int'(pll_rst), 1);
      k = 1;
      @(negedge refclk);
      relock_req = 1'b0;
      while (pll_rst === 1'b1 && k < 20) begin
         k++;
         @(negedge refclk);
      end
      check("relock_pll_rst_width", k, 4);

      // Reach RUN, then a one-cycle reset mid-run replays the sequence.
      pll_locked = 1'b1;
      wait_ready(k);
      check("rerun_ready", int'(ready), 1);
      check("rerun_loss_kept", int'(lock_loss_cnt), 255);
      rst = 1'b1;
      pll_locked = 1'b0;
      @(negedge refclk);
      check_reset_outputs("midrun_rst");
      nominal("replay");

      repeat (5) @(negedge refclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
